lsu_queue: RTL and testbench

Parametrised load/store unit that sits between the core's execute stage and the data memory. It replaces the single-outstanding `mem_stage` valid/yumi sequencer with a queue that supports up to `depth_p` in-flight memory operations. It issues one registered request per accepted op, tracks destination register and byte-lane metadata in order, and returns aligned responses to writeback. Memory responses are assumed in order.

---
 rtl/lsu_queue_pkg.sv | 28 ++
 rtl/lsu_queue_track_fifo.sv | 64 ++++++
 rtl/lsu_queue.sv | 128 ++++++++++++
 tb/tb_lsu_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_queue_pkg.sv
// Shared types and helpers for the load/store queue: byte-lane type and the
// writeback data alignment function used on the response path.
package lsu_queue_pkg;

  localparam int unsigned word_width_lp = 32;

  typedef logic [1:0] lane_t;

  // Loads return the word as-is or a zero-extended little-endian byte; stores return 0.
  function automatic logic [word_width_lp-1:0] align_rsp(
    input logic                     is_load,
    input logic                     byte_op,
    input lane_t                    lane,
    input logic [word_width_lp-1:0] data
  );
    logic [7:0] byte_sel;
    case (lane)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    if (!is_load)     return '0;
    else if (byte_op) return {24'b0, byte_sel};
    else              return data;
  endfunction

endpackage

// File: rtl/lsu_queue_track_fifo.sv
// In-order circular FIFO holding per-op writeback metadata for lsu_queue.
// Storage is payload-only; pointers and count carry all control state.
module lsu_track_fifo #(
  parameter type         entry_t  = logic,
  parameter int unsigned depth_p  = 4,
  localparam int unsigned cnt_width_lp = $clog2(depth_p + 1),
  localparam int unsigned ptr_width_lp = $clog2(depth_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  entry_t                  data_i,
  input  logic                    pop_i,
  output entry_t                  data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_width_lp-1:0] count_o
);

  entry_t                  mem_q [depth_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;

  // depth_p is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + ptr_width_lp'(1);
    if (pop_i)  rptr_d = rptr_q + ptr_width_lp'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read
  // when count_q says they are valid, so resetting them would only cost area.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == cnt_width_lp'(depth_p));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/lsu_queue.sv
// Multi-outstanding load/store unit: registered issue stage toward dmem, an
// in-order tracking FIFO, and a combinational aligned response path to writeback.
module lsu_queue
  import lsu_queue_pkg::*;
#(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned rd_width_p   = 5,
  parameter int unsigned depth_p      = 4,
  parameter int unsigned cnt_width_p  = $clog2(depth_p + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wen_i,
  input  logic                    req_byte_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  input  logic [data_width_p-1:0] req_wdata_i,
  input  logic [rd_width_p-1:0]   req_rd_i,
  output logic                    mem_valid_o,
  output logic                    mem_wen_o,
  output logic                    mem_byte_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0] mem_wdata_o,
  input  logic                    mem_yumi_i,
  input  logic                    mem_rsp_valid_i,
  input  logic [data_width_p-1:0] mem_rsp_data_i,
  output logic                    mem_rsp_yumi_o,
  output logic                    rsp_valid_o,
  output logic [data_width_p-1:0] rsp_data_o,
  output logic [rd_width_p-1:0]   rsp_rd_o,
  output logic                    rsp_is_load_o,
  input  logic                    rsp_yumi_i,
  output logic [cnt_width_p-1:0]  outstanding_o,
  output logic                    err_o
);

  typedef struct packed {
    logic                    wen;
    logic                    byte_op;
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] wdata;
    logic [rd_width_p-1:0]   rd;
  } lsu_req_s;

  typedef struct packed {
    logic [rd_width_p-1:0] rd;
    logic                  is_load;
    logic                  byte_op;
    lane_t                 lane;
  } lsu_track_s;

  lsu_req_s   req_q, req_d;
  logic       issue_v_q, issue_v_d;
  logic       err_q, err_d;
  lsu_track_s push_entry, head;
  logic       fifo_full, fifo_empty;
  logic       accept, issue_done;

  assign issue_done  = issue_v_q & mem_yumi_i;
  assign req_ready_o = ~fifo_full & (~issue_v_q | mem_yumi_i);
  assign accept      = req_valid_i & req_ready_o;

  assign push_entry.rd      = req_rd_i;
  assign push_entry.is_load = ~req_wen_i;
  assign push_entry.byte_op = req_byte_i;
  assign push_entry.lane    = req_addr_i[1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_d     = req_q;
    issue_v_d = issue_v_q;
    if (accept) begin
      req_d     = '{wen: req_wen_i, byte_op: req_byte_i, addr: req_addr_i,
                    wdata: req_wdata_i, rd: req_rd_i};
      issue_v_d = 1'b1;
    end else if (issue_done) begin
      issue_v_d = 1'b0;
    end
  end

  // Stray handshakes are flagged sticky and otherwise have no effect.
  assign err_d = err_q | (mem_rsp_valid_i & fifo_empty) | (mem_yumi_i & ~issue_v_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= '0;
      issue_v_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      req_q     <= req_d;
      issue_v_q <= issue_v_d;
      err_q     <= err_d;
    end
  end

  lsu_track_fifo #(
    .entry_t (lsu_track_s),
    .depth_p (depth_p)
  ) u_track (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (accept),
    .data_i  (push_entry),
    .pop_i   (mem_rsp_yumi_o),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign mem_valid_o = issue_v_q;
  assign mem_wen_o   = req_q.wen;
  assign mem_byte_o  = req_q.byte_op;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;

  // Head metadata is only meaningful while a response is valid; gate it otherwise.
  assign rsp_valid_o    = mem_rsp_valid_i & ~fifo_empty;
  assign mem_rsp_yumi_o = rsp_yumi_i & rsp_valid_o;
  assign rsp_is_load_o  = rsp_valid_o & head.is_load;
  assign rsp_rd_o       = rsp_is_load_o ? head.rd : '0;
  assign rsp_data_o     = rsp_valid_o ?
                          align_rsp(head.is_load, head.byte_op, head.lane, mem_rsp_data_i) : '0;
  assign err_o          = err_q;

endmodule

// File: tb/tb_lsu_queue.sv
// Directed self-checking bench for lsu_queue (depth 4): loads, byte alignment,
// full/backpressure, held responses, dmem stall, error flag and async reset.
module tb_lsu_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, req_wen_i, req_byte_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_valid_o, mem_wen_o, mem_byte_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_yumi_i, mem_rsp_valid_i, mem_rsp_yumi_o;
  logic [31:0] mem_rsp_data_i;
  logic        rsp_valid_o, rsp_is_load_o, rsp_yumi_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_queue dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
    .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i), .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o),
    .mem_byte_o(mem_byte_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_yumi_i(mem_yumi_i), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_yumi_o(mem_rsp_yumi_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
    .rsp_is_load_o(rsp_is_load_o), .rsp_yumi_i(rsp_yumi_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic byte_op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_byte_i  = byte_op;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_rd_i    = rd;
  endtask

  // Accept one load, let dmem take it, then return rsp_data and commit.
  task automatic load_roundtrip(input string tag, input logic byte_op, input logic [31:0] addr,
                                input logic [4:0] rd, input int delay,
                                input logic [31:0] data, input logic [31:0] exp);
    drive_req(1'b0, byte_op, addr, 32'h0, rd);
    #1 check({tag, "_ready"}, req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    check({tag, "_mem_valid"}, mem_valid_o, 1);
    check({tag, "_mem_addr"}, mem_addr_o, addr);
    check({tag, "_outst1"}, outstanding_o, 1);
    mem_yumi_i = 1'b1;
    tick();
    mem_yumi_i = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = data;
    rsp_yumi_i      = 1'b1;
    #1;
    check({tag, "_rsp_valid"}, rsp_valid_o, 1);
    check({tag, "_rsp_data"}, rsp_data_o, exp);
    check({tag, "_rsp_rd"}, rsp_rd_o, rd);
    check({tag, "_is_load"}, rsp_is_load_o, 1);
    check({tag, "_rsp_yumi"}, mem_rsp_yumi_o, 1);
    tick();
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    #1 check({tag, "_outst0"}, outstanding_o, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid_i = 1'b0; req_wen_i = 1'b0; req_byte_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    mem_yumi_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; rsp_yumi_i = 1'b0;
    #2;
    check("rst_ready", req_ready_o, 1);
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_mem_wen", mem_wen_o, 0);
    check("rst_mem_byte", mem_byte_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_yumi", mem_rsp_yumi_o, 0);
    check("rst_outst", outstanding_o, 0);
    check("rst_err", err_o, 0);
    tick();
    reset = 1'b1;
    tick();

    load_roundtrip("word", 1'b0, 32'h10, 5'd3, 2, 32'hDEADBEEF, 32'hDEADBEEF);
    load_roundtrip("byte3", 1'b1, 32'h13, 5'd4, 0, 32'hAABBCCDD, 32'h000000AA);
    load_roundtrip("byte0", 1'b1, 32'h10, 5'd5, 0, 32'hAABBCCDD, 32'h000000DD);
    load_roundtrip("byte1", 1'b1, 32'h21, 5'd6, 1, 32'hAABBCCDD, 32'h000000CC);

    // Fill to depth with dmem yumi every cycle after the first issue.
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 5'(10 + i));
      mem_yumi_i = (i != 0);
      #1 check("fill_ready", req_ready_o, 1);
      tick();
    end
    drive_req(1'b0, 1'b0, 32'h110, 32'h0, 5'd14);
    mem_yumi_i = 1'b1;
    #1;
    check("full_ready", req_ready_o, 0);
    check("full_outst", outstanding_o, 4);
    tick();
    mem_yumi_i      = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h1;
    rsp_yumi_i      = 1'b1;
    #1;
    check("full_head_rd", rsp_rd_o, 10);
    check("full_commit_ready", req_ready_o, 0);
    tick();
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    #1;
    check("after_commit_ready", req_ready_o, 1);
    check("after_commit_outst", outstanding_o, 3);
    tick();
    req_valid_i = 1'b0;
    check("fifth_outst", outstanding_o, 4);
    check("fifth_mem_addr", mem_addr_o, 32'h110);
    mem_yumi_i = 1'b1;
    tick();
    mem_yumi_i      = 1'b0;
    mem_rsp_valid_i = 1'b1;
    rsp_yumi_i      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("order_rd", rsp_rd_o, 11 + i);
      tick();
    end
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    #1 check("drain_outst", outstanding_o, 0);

    // Held response: writeback stalls three cycles.
    drive_req(1'b0, 1'b0, 32'h20, 32'h0, 5'd7);
    tick();
    req_valid_i = 1'b0;
    mem_yumi_i  = 1'b1;
    tick();
    mem_yumi_i      = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_yumi", mem_rsp_yumi_o, 0);
      check("hold_data", rsp_data_o, 32'h12345678);
      check("hold_outst", outstanding_o, 1);
      tick();
    end
    rsp_yumi_i = 1'b1;
    #1 check("hold_commit", mem_rsp_yumi_o, 1);
    tick();
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    #1 check("hold_outst0", outstanding_o, 0);

    // Store then load with dmem stalling the store two cycles.
    drive_req(1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 5'd0);
    tick();
    drive_req(1'b0, 1'b0, 32'h44, 32'h0, 5'd9);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_ready", req_ready_o, 0);
      check("stall_valid", mem_valid_o, 1);
      check("stall_wen", mem_wen_o, 1);
      check("stall_addr", mem_addr_o, 32'h40);
      check("stall_wdata", mem_wdata_o, 32'hCAFEF00D);
      tick();
    end
    mem_yumi_i = 1'b1;
    #1 check("b2b_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    check("b2b_wen", mem_wen_o, 0);
    check("b2b_addr", mem_addr_o, 32'h44);
    check("b2b_outst", outstanding_o, 2);
    tick();
    mem_yumi_i      = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hFFFFFFFF;
    rsp_yumi_i      = 1'b1;
    #1;
    check("st_is_load", rsp_is_load_o, 0);
    check("st_data", rsp_data_o, 0);
    check("st_rd", rsp_rd_o, 0);
    tick();
    mem_rsp_data_i = 32'h55;
    #1;
    check("ld_is_load", rsp_is_load_o, 1);
    check("ld_data", rsp_data_o, 32'h55);
    check("ld_rd", rsp_rd_o, 9);
    tick();
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    #1;
    check("st_ld_outst0", outstanding_o, 0);
    check("no_err_yet", err_o, 0);

    // Stray response with an empty queue.
    mem_rsp_valid_i = 1'b1;
    rsp_yumi_i      = 1'b1;
    #1;
    check("stray_rsp_valid", rsp_valid_o, 0);
    check("stray_rsp_yumi", mem_rsp_yumi_o, 0);
    tick();
    mem_rsp_valid_i = 1'b0;
    rsp_yumi_i      = 1'b0;
    check("err_set", err_o, 1);
    check("err_outst", outstanding_o, 0);
    tick();
    check("err_sticky", err_o, 1);

    // Async reset with two ops in flight and a response pending.
    drive_req(1'b0, 1'b0, 32'h80, 32'h0, 5'd1);
    tick();
    drive_req(1'b0, 1'b0, 32'h84, 32'h0, 5'd2);
    mem_yumi_i = 1'b1;
    tick();
    req_valid_i     = 1'b0;
    mem_yumi_i      = 1'b0;
    mem_rsp_valid_i = 1'b1;
    #1;
    check("pre_rst_outst", outstanding_o, 2);
    check("pre_rst_rsp_valid", rsp_valid_o, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_outst", outstanding_o, 0);
    check("mid_rst_mem_valid", mem_valid_o, 0);
    check("mid_rst_mem_addr", mem_addr_o, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    check("mid_rst_err", err_o, 0);
    mem_rsp_valid_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
